// File: rtl/nn_output_classifier_if.sv
// rtl/nn_output_classifier_if.sv - score input and hazard decision handshake bundle for nn_output_classifier
interface nn_output_classifier_if #(
   parameter int NUM_CLASSES = 15
);
   logic                      nn_done;
   logic [16*NUM_CLASSES-1:0] nn_outputs;
   logic [15:0]               threshold;
   logic                      class_ready;
   logic                      class_valid;
   logic [3:0]                class_id;
   logic [15:0]               class_score;
   logic [15:0]               margin;
   logic                      hazard;
   logic                      busy;
   logic                      overrun;

   modport master (
      output nn_done, nn_outputs, threshold, class_ready,
      input  class_valid, class_id, class_score, margin, hazard, busy, overrun
   );

   modport slave (
      input  nn_done, nn_outputs, threshold, class_ready,
      output class_valid, class_id, class_score, margin, hazard, busy, overrun
   );
endinterface

// File: rtl/nn_output_classifier.sv
// rtl/nn_output_classifier.sv - sequential winner/runner-up scan of NN scores into a hazard decision
// Optional build macro: CLASSIFIER_HYSTERESIS_EN (winner must persist HYST_FRAMES frames).
module nn_output_classifier #(
   parameter int NUM_CLASSES = 15,
   parameter int BG_CLASS    = 0,
   parameter int HYST_FRAMES = 2
) (
   input  logic                  clk,
   input  logic                  rst,
   nn_output_classifier_if.slave bus
);
   typedef enum logic [1:0] {IDLE, SCAN, RESULT} state_t;

   localparam logic [4:0] LAST = 5'(NUM_CLASSES);

   state_t             state, state_nx;
   logic signed [15:0] bank [16];
   logic signed [15:0] best, second;
   logic [3:0]         best_idx;
   logic [4:0]         idx;
   logic [255:0]       padded;
   logic signed [15:0] v;
   logic               handshake, capture, drop, scan_done;
   logic signed [16:0] diff;
   logic [15:0]        sat_margin;
   logic [3:0]         report_id;
   logic               report_hazard;

   logic               valid_q, hazard_q, overrun_q;
   logic [3:0]         id_q;
   logic [15:0]        score_q, margin_q;

   assign padded    = 256'(bus.nn_outputs);
   assign v         = bank[idx[3:0]];
   assign handshake = (state == RESULT) && bus.class_ready;
   assign capture   = bus.nn_done && ((state == IDLE) || handshake);
   assign drop      = bus.nn_done && ((state == SCAN) || ((state == RESULT) && !bus.class_ready));
   assign scan_done = (state == SCAN) && (idx == LAST);

   // best never drops below second, so the difference is non-negative; only the top end saturates
   assign diff       = {best[15], best} - {second[15], second};
   assign sat_margin = diff[15] ? 16'h7FFF : diff[15:0];

`ifdef CLASSIFIER_HYSTERESIS_EN
   localparam int CW = (HYST_FRAMES < 4) ? 2 : $clog2(HYST_FRAMES + 1);

   logic [3:0]    stable, cand, stable_nx, cand_nx;
   logic [CW-1:0] cnt, cnt_nx;

   always_comb begin
      stable_nx = stable;
      cand_nx   = cand;
      cnt_nx    = cnt;
      if (best_idx == stable) begin
         cnt_nx = '0;
      end else if (best_idx == cand) begin
         if ((cnt + 1'b1) >= CW'(HYST_FRAMES)) begin
            stable_nx = cand;
            cnt_nx    = '0;
         end else begin
            cnt_nx = cnt + 1'b1;
         end
      end else begin
         cand_nx = best_idx;
         if (HYST_FRAMES <= 1) begin
            stable_nx = best_idx;
            cnt_nx    = '0;
         end else begin
            cnt_nx = CW'(1);
         end
      end
      report_id     = stable_nx;
      report_hazard = (stable_nx != 4'(BG_CLASS)) && (best >= $signed(bus.threshold))
                      && (best_idx == stable_nx);
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         stable <= 4'(BG_CLASS);
         cand   <= 4'(BG_CLASS);
         cnt    <= '0;
      end else if (scan_done) begin
         stable <= stable_nx;
         cand   <= cand_nx;
         cnt    <= cnt_nx;
      end
   end
`else
   always_comb begin
      report_id     = best_idx;
      report_hazard = (best_idx != 4'(BG_CLASS)) && (best >= $signed(bus.threshold));
   end
`endif

   always_ff @(posedge clk or posedge rst) begin
      if (rst) state <= IDLE;
      else     state <= state_nx;
   end

   always_comb begin
      state_nx = state;
      case (state)
         IDLE:    if (capture) state_nx = SCAN;
         SCAN:    if (idx == LAST) state_nx = RESULT;
         RESULT:  if (handshake) state_nx = capture ? SCAN : IDLE;
         default: state_nx = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < 16; i++) bank[i] <= '0;
         best      <= '0;
         second    <= '0;
         best_idx  <= '0;
         idx       <= '0;
         valid_q   <= 1'b0;
         id_q      <= '0;
         score_q   <= '0;
         margin_q  <= '0;
         hazard_q  <= 1'b0;
         overrun_q <= 1'b0;
      end else begin
         if (capture) begin
            for (int i = 0; i < 16; i++) bank[i] <= padded[16*i +: 16];
            best     <= padded[15:0];
            best_idx <= '0;
            second   <= 16'sh8000;
            idx      <= 5'd1;
         end else if ((state == SCAN) && (idx != LAST)) begin
            // strict compares keep the lowest index on ties
            if (v > best) begin
               second   <= best;
               best     <= v;
               best_idx <= idx[3:0];
            end else if (v > second) begin
               second <= v;
            end
            idx <= idx + 5'd1;
         end

         if (scan_done) begin
            valid_q  <= 1'b1;
            id_q     <= report_id;
            score_q  <= best;
            margin_q <= sat_margin;
            hazard_q <= report_hazard;
         end else if (handshake) begin
            valid_q <= 1'b0;
         end

         if (drop) overrun_q <= 1'b1;
      end
   end

   assign bus.class_valid = valid_q;
   assign bus.class_id    = id_q;
   assign bus.class_score = score_q;
   assign bus.margin      = margin_q;
   assign bus.hazard      = hazard_q;
   assign bus.busy        = (state != IDLE);
   assign bus.overrun     = overrun_q;
endmodule

// File: tb/tb_nn_output_classifier.sv
// tb/tb_nn_output_classifier.sv - directed-vector self-checking bench for nn_output_classifier
module tb_nn_output_classifier;
   localparam int NC = 15;

   logic clk = 1'b0;
   logic rst;
   int   total = 0;
   int   bad   = 0;
   int   lat;
   logic [16*NC-1:0] sc;
   logic [3:0]       exp_id [4];
   logic             exp_hz [4];
   logic [3:0]       win    [4];

   always #5 clk = ~clk;

   nn_output_classifier_if #(.NUM_CLASSES(NC)) bus ();

   nn_output_classifier #(
      .NUM_CLASSES(NC),
      .BG_CLASS(0),
      .HYST_FRAMES(2)
   ) dut (
      .clk(clk),
      .rst(rst),
      .bus(bus)
   );

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s got=%h exp=%h", tag, got, exp);
      end
   endtask

   function automatic logic [16*NC-1:0] fill(input logic [15:0] val);
      logic [16*NC-1:0] r;
      for (int i = 0; i < NC; i++) r[16*i +: 16] = val;
      return r;
   endfunction

   // pulse nn_done for one cycle, then scramble the inputs to prove they were captured
   task automatic send_frame(input logic [16*NC-1:0] s);
      bus.nn_outputs = s;
      bus.nn_done    = 1'b1;
      @(negedge clk);
      bus.nn_done    = 1'b0;
      bus.nn_outputs = {8{$urandom}};
   endtask

   task automatic wait_valid(output int n);
      n = 0;
      while (!bus.class_valid && n < 40) begin
         @(negedge clk);
         n++;
      end
   endtask

   task automatic accept();
      bus.class_ready = 1'b1;
      @(negedge clk);
      bus.class_ready = 1'b0;
   endtask

   task automatic do_reset();
      rst = 1'b1;
      repeat (2) @(negedge clk);
      rst = 1'b0;
   endtask

   initial begin
      bus.nn_done     = 1'b0;
      bus.nn_outputs  = '0;
      bus.threshold   = 16'h0100;
      bus.class_ready = 1'b0;
      rst             = 1'b1;
      repeat (2) @(negedge clk);
      check("rst_valid", 32'(bus.class_valid), 32'd0);
      check("rst_busy", 32'(bus.busy), 32'd0);
      check("rst_overrun", 32'(bus.overrun), 32'd0);
      check("rst_id", 32'(bus.class_id), 32'd0);
      check("rst_score", 32'(bus.class_score), 32'd0);
      rst = 1'b0;
      @(negedge clk);

      // single clear winner
      sc = fill(16'h0000);
      sc[16*7 +: 16] = 16'h0300;
      send_frame(sc);
      check("t1_busy", 32'(bus.busy), 32'd1);
      wait_valid(lat);
      check("t1_latency", 32'(lat), 32'd15);
      check("t1_id", 32'(bus.class_id), 32'd7);
      check("t1_score", 32'(bus.class_score), 32'h0300);
      check("t1_margin", 32'(bus.margin), 32'h0300);
      check("t1_hazard", 32'(bus.hazard), 32'd1);
      accept();
      check("t1_release", 32'(bus.class_valid), 32'd0);
      check("t1_idle", 32'(bus.busy), 32'd0);

      // tie goes to the lower index
      sc = fill(16'hFF00);
      sc[16*3 +: 16] = 16'h0200;
      sc[16*9 +: 16] = 16'h0200;
      send_frame(sc);
      wait_valid(lat);
      check("t2_id", 32'(bus.class_id), 32'd3);
      check("t2_margin", 32'(bus.margin), 32'h0000);
      check("t2_hazard", 32'(bus.hazard), 32'd1);
      accept();

      // all negative, background wins
      sc = fill(16'hFF00);
      sc[15:0] = 16'hFFF0;
      send_frame(sc);
      wait_valid(lat);
      check("t3_id", 32'(bus.class_id), 32'd0);
      check("t3_margin", 32'(bus.margin), 32'h00F0);
      check("t3_hazard", 32'(bus.hazard), 32'd0);
      accept();

      // margin saturation
      sc = fill(16'h8000);
      sc[16*4 +: 16] = 16'h7FFF;
      send_frame(sc);
      wait_valid(lat);
      check("t4_id", 32'(bus.class_id), 32'd4);
      check("t4_margin", 32'(bus.margin), 32'h7FFF);
      accept();

      // threshold boundary: equal passes, one LSB above fails
      sc = fill(16'h0000);
      sc[16*2 +: 16] = 16'h0100;
      send_frame(sc);
      wait_valid(lat);
      check("thr_eq_hazard", 32'(bus.hazard), 32'd1);
      accept();
      bus.threshold = 16'h0101;
      send_frame(sc);
      wait_valid(lat);
      check("thr_above_hazard", 32'(bus.hazard), 32'd0);
      accept();
      bus.threshold = 16'h0100;

      // nn_done mid-scan is dropped
      sc = fill(16'h0000);
      sc[16*7 +: 16] = 16'h0300;
      send_frame(sc);
      repeat (4) @(negedge clk);
      sc = fill(16'h0000);
      sc[16*11 +: 16] = 16'h0700;
      send_frame(sc);
      check("t5_overrun", 32'(bus.overrun), 32'd1);
      wait_valid(lat);
      check("t5_id", 32'(bus.class_id), 32'd7);
      check("t5_score", 32'(bus.class_score), 32'h0300);
      accept();
      do_reset();
      check("t5_overrun_cleared", 32'(bus.overrun), 32'd0);

      // backpressure hold, then back-to-back frame on the handshake
      sc = fill(16'h0000);
      sc[16*7 +: 16] = 16'h0300;
      send_frame(sc);
      wait_valid(lat);
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         check("t6_hold_valid", 32'(bus.class_valid), 32'd1);
         check("t6_hold_id", 32'(bus.class_id), 32'd7);
      end
      sc = fill(16'h0000);
      sc[16*9 +: 16] = 16'h0500;
      bus.class_ready = 1'b1;
      send_frame(sc);
      bus.class_ready = 1'b0;
      check("t6_valid_drop", 32'(bus.class_valid), 32'd0);
      check("t6_busy", 32'(bus.busy), 32'd1);
      check("t6_overrun", 32'(bus.overrun), 32'd0);
      wait_valid(lat);
      check("t6_latency", 32'(lat), 32'd15);
      check("t6_id", 32'(bus.class_id), 32'd9);
      check("t6_score", 32'(bus.class_score), 32'h0500);
      accept();

      // winner sequence 5,5,2,5
      win[0] = 4'd5; win[1] = 4'd5; win[2] = 4'd2; win[3] = 4'd5;
`ifdef CLASSIFIER_HYSTERESIS_EN
      exp_id[0] = 4'd0; exp_id[1] = 4'd5; exp_id[2] = 4'd5; exp_id[3] = 4'd5;
      exp_hz[0] = 1'b0; exp_hz[1] = 1'b1; exp_hz[2] = 1'b0; exp_hz[3] = 1'b1;
`else
      exp_id[0] = 4'd5; exp_id[1] = 4'd5; exp_id[2] = 4'd2; exp_id[3] = 4'd5;
      exp_hz[0] = 1'b1; exp_hz[1] = 1'b1; exp_hz[2] = 1'b1; exp_hz[3] = 1'b1;
`endif
      for (int f = 0; f < 4; f++) begin
         sc = fill(16'h0000);
         sc[16*win[f] +: 16] = 16'h0300;
         send_frame(sc);
         wait_valid(lat);
         check($sformatf("t7_id_f%0d", f), 32'(bus.class_id), 32'(exp_id[f]));
         check($sformatf("t7_hazard_f%0d", f), 32'(bus.hazard), 32'(exp_hz[f]));
         accept();
      end

      // async reset mid-scan clears everything without a clock edge
      send_frame(sc);
      repeat (2) @(negedge clk);
      send_frame(sc);
      check("t8_pre_overrun", 32'(bus.overrun), 32'd1);
      @(posedge clk);
      #2 rst = 1'b1;
      #1;
      check("t8_valid", 32'(bus.class_valid), 32'd0);
      check("t8_busy", 32'(bus.busy), 32'd0);
      check("t8_overrun", 32'(bus.overrun), 32'd0);
      @(negedge clk);
      rst = 1'b0;
      repeat (20) @(negedge clk);
      check("t8_no_result", 32'(bus.class_valid), 32'd0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
